// File: rtl/pq_pkg.sv
// Shared types for the hardware priority queue family: <key,value> pair and sentinels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pq_pkg;

  parameter int KEY_WIDTH   = 4;
  parameter int VAL_WIDTH   = 4;
  parameter int PQ_CAPACITY = 4;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  // Largest key; also the key carried by an empty slot.
  parameter logic [KEY_WIDTH-1:0] KEYINF = '1;
  parameter kv_t KV_EMPTY = '{key: KEYINF, val: '0};

endpackage

// File: rtl/pq_sorted_array_if.sv
// Enqueue/dequeue bundle between a producer/consumer and a priority queue.
// Latency: n/a (wires only).
// Backpressure: none in-band; master reads full/empty, queue reports drops on err.
//
// master: drives enq, kvi, deq; observes kvo, count, full, empty, err.
// slave : the queue, the reverse directions.
interface pq_sorted_array_if #(
  parameter int CAPACITY = pq_pkg::PQ_CAPACITY
);
  logic                               enq;
  pq_pkg::kv_t                        kvi;
  logic                               deq;
  pq_pkg::kv_t                        kvo;
  logic [$clog2(CAPACITY+1)-1:0]      count;
  logic                               full;
  logic                               empty;
  logic                               err;

  modport master (
    output enq, kvi, deq,
    input  kvo, count, full, empty, err
  );

  modport slave (
    input  enq, kvi, deq,
    output kvo, count, full, empty, err
  );
endinterface

// File: rtl/pq_sorted_array.sv
// Sorted shift-register priority queue; head (minimum key, FIFO on ties) on kvo.
// Latency: request at edge t visible on kvo/count/full/empty right after edge t.
// Backpressure: none; producer/consumer watch full/empty, dropped requests pulse err.
//
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset
//   pq    - slave side of pq_sorted_array_if (enq/kvi/deq in, kvo/count/full/empty/err out)
module pq_sorted_array #(
  parameter int CAPACITY = pq_pkg::PQ_CAPACITY
) (
  input  logic                clk,
  input  logic                rst_n,
  pq_sorted_array_if.slave    pq
);
  import pq_pkg::*;

  localparam int            CW    = $clog2(CAPACITY + 1);
  localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

  kv_t           slot_q [CAPACITY];
  kv_t           slot_d [CAPACITY];
  kv_t           rem    [CAPACITY];   // contents after any same-cycle removal
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_rem;
  logic          err_q, err_d;
  logic          full_w, empty_w;
  logic          do_deq, do_enq;
  logic [CAPACITY-1:0] gt;            // slot lies at or above the insert position
  logic [CAPACITY-1:0] ins_here;      // exactly one bit: the insert position

  assign full_w  = (count_q == CAP_C);
  assign empty_w = (count_q == '0);

  // Dequeue needs an entry; enqueue needs room, which a same-cycle dequeue provides.
  // With enq+deq on an empty queue do_deq is 0 and the enqueue still proceeds.
  assign do_deq = pq.deq && !empty_w;
  assign do_enq = pq.enq && (!full_w || do_deq);

  always_comb begin
    // Stage 1: optional shift down (head removal).
    for (int i = 0; i < CAPACITY - 1; i++) begin
      rem[i] = do_deq ? slot_q[i+1] : slot_q[i];
    end
    rem[CAPACITY-1] = do_deq ? KV_EMPTY : slot_q[CAPACITY-1];
    n_rem = do_deq ? (count_q - CW'(1)) : count_q;

    // Stage 2: parallel compare. Strict '>' puts a new key after equal keys (FIFO ties).
    // Validity comes from n_rem, so a real KEYINF entry is never mistaken for empty.
    // gt is a thermometer because valid slots are sorted and every slot >= n_rem is set.
    for (int i = 0; i < CAPACITY; i++) begin
      gt[i] = (CW'(i) >= n_rem) || (rem[i].key > pq.kvi.key);
    end
    ins_here[0] = gt[0];
    for (int i = 1; i < CAPACITY; i++) begin
      ins_here[i] = gt[i] && !gt[i-1];
    end

    // Stage 3: per-slot mux hold / shift-up / load kvi on top of the removal result.
    for (int i = 0; i < CAPACITY; i++) begin
      slot_d[i] = rem[i];
    end
    if (do_enq) begin
      slot_d[0] = gt[0] ? pq.kvi : rem[0];
      for (int i = 1; i < CAPACITY; i++) begin
        if (ins_here[i]) begin
          slot_d[i] = pq.kvi;
        end else if (gt[i]) begin
          slot_d[i] = rem[i-1];
        end
      end
    end

    count_d = count_q;
    if (do_enq && !do_deq) begin
      count_d = count_q + CW'(1);
    end else if (do_deq && !do_enq) begin
      count_d = count_q - CW'(1);
    end

    err_d = (pq.enq && !pq.deq && full_w)  ||
            (pq.deq && !pq.enq && empty_w) ||
            (pq.enq && pq.deq  && empty_w);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CAPACITY; i++) begin
        slot_q[i] <= KV_EMPTY;
      end
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign pq.kvo   = slot_q[0];
  assign pq.count = count_q;
  assign pq.full  = full_w;
  assign pq.empty = empty_w;
  assign pq.err   = err_q;

endmodule

// File: tb/tb_pq_sorted_array.sv
module tb_pq_sorted_array;
  import pq_pkg::*;

  logic clk;
  logic rst_n;

  pq_sorted_array_if #(.CAPACITY(4)) pq_bus ();

  pq_sorted_array #(.CAPACITY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pq    (pq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       enq;
    logic       deq;
    logic [7:0] kvi;
    logic [7:0] kvo;
    int         cnt;
    logic       full;
    logic       empty;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_applied;
  int   n_miscmp;

  task automatic add(input logic r, input logic e, input logic d, input logic [7:0] ki,
                     input logic [7:0] ko, input int c, input logic f, input logic em,
                     input logic er);
    vec_t v;
    v.rst_n = r; v.enq = e; v.deq = d; v.kvi = ki;
    v.kvo = ko; v.cnt = c; v.full = f; v.empty = em; v.err = er;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
  task automatic cyc(input logic r, input logic e, input logic d, input logic [7:0] ki);
    rst_n      = r;
    pq_bus.enq = e;
    pq_bus.deq = d;
    pq_bus.kvi = ki;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] ko, input int c,
                       input logic f, input logic em, input logic er);
    n_applied++;
    if (pq_bus.kvo !== ko || int'(pq_bus.count) != c || pq_bus.full !== f ||
        pq_bus.empty !== em || pq_bus.err !== er) begin
      n_miscmp++;
      $display("FAIL %s: got kvo=%h count=%0d full=%b empty=%b err=%b, want kvo=%h count=%0d full=%b empty=%b err=%b",
               name, pq_bus.kvo, pq_bus.count, pq_bus.full, pq_bus.empty, pq_bus.err,
               ko, c, f, em, er);
    end
  endtask

  initial begin
    n_applied = 0;
    n_miscmp  = 0;
    rst_n      = 1'b0;
    pq_bus.enq = 1'b0;
    pq_bus.deq = 1'b0;
    pq_bus.kvi = 8'h00;
    #2;

    //   rst enq deq kvi     kvo   cnt full empty err
    add(0, 0, 0, 8'h00,   8'hF0, 0, 0, 1, 0);  // reset
    add(1, 0, 0, 8'h00,   8'hF0, 0, 0, 1, 0);  // idle after reset
    add(1, 1, 0, 8'h5A,   8'h5A, 1, 0, 0, 0);  // into empty: visible right after edge
    add(1, 1, 0, 8'h2B,   8'h2B, 2, 0, 0, 0);
    add(1, 1, 0, 8'h9C,   8'h2B, 3, 0, 0, 0);
    add(1, 1, 0, 8'h2D,   8'h2B, 4, 1, 0, 0);  // 2B,2D,5A,9C
    add(1, 1, 0, 8'h1E,   8'h2B, 4, 1, 0, 1);  // overflow dropped
    add(1, 0, 0, 8'h00,   8'h2B, 4, 1, 0, 0);  // err clears, contents kept
    add(1, 1, 1, 8'h7E,   8'h2D, 4, 1, 0, 0);  // replace: 2D,5A,7E,9C
    add(1, 1, 1, 8'h01,   8'h01, 4, 1, 0, 0);  // replace: 01,5A,7E,9C
    add(1, 0, 1, 8'h00,   8'h5A, 3, 0, 0, 0);  // drain
    add(1, 0, 1, 8'h00,   8'h7E, 2, 0, 0, 0);
    add(1, 0, 1, 8'h00,   8'h9C, 1, 0, 0, 0);
    add(1, 0, 1, 8'h00,   8'hF0, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00,   8'hF0, 0, 0, 1, 1);  // underflow
    add(1, 1, 0, 8'hF3,   8'hF3, 1, 0, 0, 0);  // KEYINF is a real entry
    add(1, 1, 0, 8'hF4,   8'hF3, 2, 0, 0, 0);  // tie goes behind
    add(1, 0, 1, 8'h00,   8'hF4, 1, 0, 0, 0);
    add(1, 0, 1, 8'h00,   8'hF0, 0, 0, 1, 0);
    add(1, 1, 0, 8'h33,   8'h33, 1, 0, 0, 0);  // tie inserted by replace lands after
    add(1, 1, 0, 8'h34,   8'h33, 2, 0, 0, 0);  // 33,34
    add(1, 1, 1, 8'h35,   8'h34, 2, 0, 0, 0);  // 34,35
    add(1, 0, 1, 8'h00,   8'h35, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].enq, vecs[i].deq, vecs[i].kvi);
      check($sformatf("vec%0d", i), vecs[i].kvo, vecs[i].cnt, vecs[i].full,
            vecs[i].empty, vecs[i].err);
    end

    // Reset mid-sequence with a concurrent enqueue: everything discarded.
    cyc(1, 0, 1, 8'h00);
    check("drain_last", 8'hF0, 0, 0, 1, 0);
    cyc(1, 1, 0, 8'h31);
    cyc(1, 1, 0, 8'h12);
    cyc(1, 1, 0, 8'h83);
    check("fill3", 8'h12, 3, 0, 0, 0);
    cyc(0, 1, 0, 8'h00);
    check("rst_with_enq", 8'hF0, 0, 0, 1, 0);
    cyc(1, 0, 0, 8'h00);
    check("idle_after_rst", 8'hF0, 0, 0, 1, 0);

    // enq+deq on empty: enqueue performed, dequeue ignored, err flagged.
    cyc(1, 1, 1, 8'h66);
    check("enqdeq_empty", 8'h66, 1, 0, 0, 1);
    cyc(1, 0, 0, 8'h00);
    check("err_clear", 8'h66, 1, 0, 0, 0);

    // Replace on a single entry with a larger key.
    cyc(1, 1, 1, 8'hA7);
    check("replace_one", 8'hA7, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
